// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared types, constants and helpers for the multiply/divide
// sequencer.
//   mdu_state_e    : sequencer state encoding
//   MDU_DIV_CYCLES : radix-2 iterations per divide
//   MDU_OP_MUL/DIV : encodings of mul_or_div_i
//   mdu_abs        : magnitude of an operand (signed ops only)
//   mdu_neg_if     : conditional two's-complement negate
//   mdu_mul        : 32x32 -> 64 product, signed or unsigned
package mdu_ctrl_pkg;

  localparam int   MDU_DIV_CYCLES = 32;
  localparam int   MDU_CNT_W      = 5;
  localparam logic MDU_OP_MUL     = 1'b0;
  localparam logic MDU_OP_DIV     = 1'b1;

  typedef enum logic [1:0] {
    MDU_IDLE     = 2'd0,
    MDU_DIV_BUSY = 2'd1,
    MDU_MUL_BUSY = 2'd2,
    MDU_DONE     = 2'd3
  } mdu_state_e;

  function automatic logic [31:0] mdu_abs(input logic [31:0] v, input logic is_sign);
    return (is_sign && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] mdu_neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  // Sign-extending both operands to 64 bits makes the truncated 64-bit
  // product correct for the signed case as well.
  function automatic logic [63:0] mdu_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic is_sign);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = {{32{is_sign & a[31]}}, a};
    bx = {{32{is_sign & b[31]}}, b};
    return ax * bx;
  endfunction

endpackage

// File: rtl/mdu_ctrl_div_radix2.sv
// mdu_ctrl_div_radix2: div_radix2 datapath, unsigned radix-2 restoring divider.
// One quotient bit per step; the owner sequences start/step and watches last.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   clr_i            : synchronous clear of all registers (pipeline flush)
//   start_i          : load dividend/divisor, clear remainder and counter
//   step_i           : perform one shift/trial-subtract iteration
//   dividend_i/divisor_i : unsigned operands
//   last_o           : the current step is the final iteration
//   quot_o / rem_o   : unsigned quotient and remainder registers
module mdu_ctrl_div_radix2
  import mdu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        start_i,
  input  logic        step_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        last_o,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  logic [31:0]          rem_q, rem_d;
  logic [31:0]          quot_q, quot_d;
  logic [31:0]          divisor_q;
  logic [MDU_CNT_W-1:0] cnt_q;

  // The shifted remainder needs 33 bits: it can reach 2*divisor-1.
  logic [32:0] partial;
  logic [33:0] diff;

  always_comb begin
    partial = {rem_q, quot_q[31]};
    diff    = {1'b0, partial} - {2'b00, divisor_q};
    if (!diff[33]) begin
      rem_d  = diff[31:0];
      quot_d = {quot_q[30:0], 1'b1};
    end else begin
      rem_d  = partial[31:0];
      quot_d = {quot_q[30:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
    end else if (clr_i) begin
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
    end else if (start_i) begin
      rem_q     <= '0;
      quot_q    <= dividend_i;
      divisor_q <= divisor_i;
      cnt_q     <= '0;
    end else if (step_i) begin
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      cnt_q     <= cnt_q + MDU_CNT_W'(1);
    end
  end

  assign last_o = step_i && (cnt_q == MDU_CNT_W'(MDU_DIV_CYCLES - 1));
  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide sequencer for the EX stage.
// Owns the FSM, operand sign handling, stall request and flush abort; the
// iterative divide datapath lives in mdu_ctrl_div_radix2.
// Optional feature: MDU_MUL_MULTICYCLE_EN registers the multiply (IDLE ->
// MUL_BUSY -> DONE). Undefined: combinational multiply answered in IDLE.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start_i         : valid mult/div in EX
//   mul_or_div_i    : 0 multiply, 1 divide
//   is_sign_i       : signed operation
//   a_i, b_i        : rs / rt operands
//   flush_i         : abort any operation, return to IDLE
//   hold_i          : downstream freeze; keeps DONE presenting its result
//   stall_o         : stall IF/ID/EX
//   ready_o         : hi_o/lo_o valid for HI/LO capture this cycle
//   hi_o, lo_o      : remainder/quotient or upper/lower product word
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             mul_or_div_i,
  input  logic             is_sign_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  input  logic             hold_i,
  output logic             stall_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  mdu_state_e  state_q, state_d;
  logic        q_neg_q;
  logic        r_neg_q;
  logic        div_start;
  logic        div_step;
  logic        div_last;
  logic [31:0] div_quot;
  logic [31:0] div_rem;

  assign div_start = (state_q == MDU_IDLE) && start_i && !flush_i &&
                     (mul_or_div_i == MDU_OP_DIV);
  assign div_step  = (state_q == MDU_DIV_BUSY);

  mdu_ctrl_div_radix2 u_div (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (flush_i),
    .start_i    (div_start),
    .step_i     (div_step),
    .dividend_i (mdu_abs(a_i, is_sign_i)),
    .divisor_i  (mdu_abs(b_i, is_sign_i)),
    .last_o     (div_last),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  // Result signs are captured at accept time since a_i/b_i move on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (flush_i) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (div_start) begin
      q_neg_q <= is_sign_i & (a_i[31] ^ b_i[31]);
      r_neg_q <= is_sign_i & a_i[31];
    end
  end

`ifdef MDU_MUL_MULTICYCLE_EN
  logic        mul_start;
  logic [31:0] mul_a_q;
  logic [31:0] mul_b_q;
  logic        mul_sign_q;
  logic [63:0] prod_q;
  logic        res_is_mul_q;

  assign mul_start = (state_q == MDU_IDLE) && start_i && !flush_i &&
                     (mul_or_div_i == MDU_OP_MUL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_sign_q   <= 1'b0;
      prod_q       <= '0;
      res_is_mul_q <= 1'b0;
    end else if (flush_i) begin
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_sign_q   <= 1'b0;
      prod_q       <= '0;
      res_is_mul_q <= 1'b0;
    end else begin
      if (mul_start) begin
        mul_a_q      <= a_i;
        mul_b_q      <= b_i;
        mul_sign_q   <= is_sign_i;
        res_is_mul_q <= 1'b1;
      end else if (div_start) begin
        res_is_mul_q <= 1'b0;
      end
      if (state_q == MDU_MUL_BUSY) begin
        prod_q <= mdu_mul(mul_a_q, mul_b_q, mul_sign_q);
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MDU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    ready_o = 1'b0;
    hi_o    = '0;
    lo_o    = '0;
    case (state_q)
      MDU_IDLE: begin
        if (start_i && !flush_i) begin
          if (mul_or_div_i == MDU_OP_DIV) begin
            state_d = MDU_DIV_BUSY;
            stall_o = 1'b1;
          end else begin
`ifdef MDU_MUL_MULTICYCLE_EN
            state_d = MDU_MUL_BUSY;
            stall_o = 1'b1;
`else
            ready_o      = 1'b1;
            {hi_o, lo_o} = mdu_mul(a_i, b_i, is_sign_i);
`endif
          end
        end
      end
      MDU_DIV_BUSY: begin
        stall_o = 1'b1;
        if (div_last) begin
          state_d = MDU_DONE;
        end
      end
`ifdef MDU_MUL_MULTICYCLE_EN
      MDU_MUL_BUSY: begin
        stall_o = 1'b1;
        state_d = MDU_DONE;
      end
`endif
      MDU_DONE: begin
        // Sign adjustment is a fixed function of held registers, so the
        // result stays stable for as long as hold_i keeps us here.
        ready_o = 1'b1;
        hi_o    = mdu_neg_if(div_rem, r_neg_q);
        lo_o    = mdu_neg_if(div_quot, q_neg_q);
`ifdef MDU_MUL_MULTICYCLE_EN
        if (res_is_mul_q) begin
          {hi_o, lo_o} = prod_q;
        end
`endif
        if (!hold_i) begin
          state_d = MDU_IDLE;
        end
      end
      default: begin
        state_d = MDU_IDLE;
      end
    endcase
    if (flush_i) begin
      state_d = MDU_IDLE;
      ready_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op;
  logic        sgn;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        hold;
  logic        stall;
  logic        ready;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mdu_ctrl #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .mul_or_div_i (op),
    .is_sign_i    (sgn),
    .a_i          (a),
    .b_i          (b),
    .flush_i      (flush),
    .hold_i       (hold),
    .stall_o      (stall),
    .ready_o      (ready),
    .hi_o         (hi),
    .lo_o         (lo)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Issues one divide at the current cycle (cycle 0) and observes it.
  // lat = cycles from accept until ready_o; stalls = cycles with stall_o.
  task automatic run_div(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                         output int lat, output int stalls,
                         output logic [31:0] hv, output logic [31:0] lv,
                         output bit timeout);
    bit got;
    got = 0; timeout = 0; stalls = 0; lat = 0; hv = '0; lv = '0;
    a = av; b = bv; sgn = sv; op = 1'b1; start = 1'b1;
    @(negedge clk);
    if (stall) stalls++;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (ready) begin
        got = 1; lat = c; hv = hi; lv = lo;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!got) timeout = 1;
    else begin
      @(posedge clk); #1;
    end
    $display("div a=%h b=%h signed=%0d lat=%0d stalls=%0d hi=%h lo=%h timeout=%0d",
             av, bv, sv, lat, stalls, hv, lv, timeout);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 0; op = 0; sgn = 0; a = 0; b = 0; flush = 0; hold = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
    $display("reset stall=%b ready=%b hi=%h lo=%h", stall, ready, hi, lo);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mult;
    logic [63:0] exp_p [2];
    logic        sg    [2];
    exp_p[0] = 64'hFFFFFFFF_FFFFFFFE; sg[0] = 1'b1;
    exp_p[1] = 64'h00000001_FFFFFFFE; sg[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a = 32'hFFFFFFFF; b = 32'h2; sgn = sg[i]; op = 1'b0; start = 1'b1;
`ifdef MDU_MUL_MULTICYCLE_EN
      @(negedge clk);
      checks++; if (stall !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL mul_c0_%0d: stall=%b ready=%b want 1/0", i, stall, ready); end
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      checks++; if (stall !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL mul_c1_%0d: stall=%b ready=%b want 1/0", i, stall, ready); end
      @(posedge clk); #1;
      @(negedge clk);
`else
      #1;
`endif
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mul_ready_%0d: got %b want 1", i, ready); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mul_stall_%0d: got %b want 0", i, stall); end
      checks++; if ({hi, lo} !== exp_p[i]) begin errors++; $display("FAIL mul_prod_%0d: got %h want %h", i, {hi, lo}, exp_p[i]); end
      $display("mul a=%h b=%h signed=%0d ready=%b hi=%h lo=%h", a, b, sg[i], ready, hi, lo);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mul_after_%0d: ready=%b want 0", i, ready); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_signed;
    int lat, st; logic [31:0] hv, lv; bit to;
    run_div(32'd100, 32'd7, 1'b1, lat, st, hv, lv, to);
    checks++; if (to || lat !== 33) begin errors++; $display("FAIL div_pos_lat: got %0d timeout=%0d want 33", lat, to); end
    checks++; if (st !== 33) begin errors++; $display("FAIL div_pos_stall: got %0d want 33", st); end
    checks++; if (hv !== 32'd2 || lv !== 32'd14) begin errors++; $display("FAIL div_pos_res: got %h/%h want 2/e", hv, lv); end
    run_div(32'hFFFFFF9C, 32'd7, 1'b1, lat, st, hv, lv, to);
    checks++; if (to || lat !== 33) begin errors++; $display("FAIL div_neg_lat: got %0d want 33", lat); end
    checks++; if (hv !== 32'hFFFFFFFE || lv !== 32'hFFFFFFF2) begin errors++; $display("FAIL div_neg_res: got %h/%h want fffffffe/fffffff2", hv, lv); end
  endtask

  task automatic test_div_unsigned;
    int lat, st; logic [31:0] hv, lv; bit to;
    // 4294967196 = 7 * 613566742 + 2
    run_div(32'hFFFFFF9C, 32'd7, 1'b0, lat, st, hv, lv, to);
    checks++; if (to || lat !== 33) begin errors++; $display("FAIL divu_lat: got %0d want 33", lat); end
    checks++; if (hv !== 32'd2 || lv !== 32'h24924916) begin errors++; $display("FAIL divu_res: got %h/%h want 2/24924916", hv, lv); end
  endtask

  task automatic test_div_zero;
    int lat, st; logic [31:0] hv, lv; bit to;
    run_div(32'd5, 32'd0, 1'b0, lat, st, hv, lv, to);
    checks++; if (to || lat !== 33) begin errors++; $display("FAIL divz_lat: got %0d want 33", lat); end
    checks++; if (hv !== 32'd5 || lv !== 32'hFFFFFFFF) begin errors++; $display("FAIL divz_res: got %h/%h want 5/ffffffff", hv, lv); end
  endtask

  task automatic test_flush;
    int lat, st; logic [31:0] hv, lv; bit to;
    a = 32'd100; b = 32'd7; sgn = 1'b1; op = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL flush_c10_ready: got %b want 0", ready); end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checks++; if (stall !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL flush_idle: stall=%b ready=%b want 0/0", stall, ready); end
    $display("flush at cycle 10: next stall=%b ready=%b", stall, ready);
    @(posedge clk); #1;
    run_div(32'd1000, 32'd33, 1'b0, lat, st, hv, lv, to);
    checks++; if (to || lat !== 33) begin errors++; $display("FAIL flush_new_lat: got %0d want 33", lat); end
    checks++; if (hv !== 32'd10 || lv !== 32'd30) begin errors++; $display("FAIL flush_new_res: got %h/%h want a/1e", hv, lv); end
  endtask

  task automatic test_hold;
    bit got; int lat; logic [31:0] hv, lv;
    got = 0; lat = 0; hv = '0; lv = '0;
    hold = 1'b1;
    a = 32'd1000; b = 32'd33; sgn = 1'b0; op = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (ready) begin got = 1; lat = c; hv = hi; lv = lo; end
      else begin @(posedge clk); #1; end
    end
    checks++; if (!got || lat !== 33) begin errors++; $display("FAIL hold_lat: got %0d want 33", lat); end
    checks++; if (hv !== 32'd10 || lv !== 32'd30) begin errors++; $display("FAIL hold_res: got %h/%h want a/1e", hv, lv); end
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (k == 3) hold = 1'b0;
      @(negedge clk);
      checks++; if (ready !== 1'b1 || stall !== 1'b0 || hi !== 32'd10 || lo !== 32'd30) begin
        errors++; $display("FAIL hold_stable_%0d: ready=%b stall=%b hi=%h lo=%h want 1/0/a/1e", k, ready, stall, hi, lo);
      end
      $display("hold cycle %0d ready=%b hi=%h lo=%h", k, ready, hi, lo);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL hold_release: ready=%b want 0", ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int lat, st; logic [31:0] hv, lv; bit to;
    run_div(32'd100, 32'd7, 1'b1, lat, st, hv, lv, to);
    checks++; if (to || hv !== 32'd2 || lv !== 32'd14) begin errors++; $display("FAIL b2b_first: got %h/%h want 2/e", hv, lv); end
    run_div(32'h12345678, 32'h100, 1'b0, lat, st, hv, lv, to);
    checks++; if (to || lat !== 33) begin errors++; $display("FAIL b2b_lat: got %0d want 33", lat); end
    checks++; if (hv !== 32'h78 || lv !== 32'h00123456) begin errors++; $display("FAIL b2b_res: got %h/%h want 78/123456", hv, lv); end
    run_div(32'd7, 32'hFFFFFFFE, 1'b1, lat, st, hv, lv, to);
    checks++; if (to || hv !== 32'd1 || lv !== 32'hFFFFFFFD) begin errors++; $display("FAIL b2b_negdiv: got %h/%h want 1/fffffffd", hv, lv); end
  endtask

  task automatic test_async_reset;
    bit got;
    got = 0;
    a = 32'd100; b = 32'd7; sgn = 1'b1; op = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if (stall !== 1'b0 || ready !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++; $display("FAIL rst_busy: stall=%b ready=%b hi=%h lo=%h want all 0", stall, ready, hi, lo);
    end
    $display("reset mid-divide stall=%b ready=%b", stall, ready);
    @(posedge clk); #1;
    rst = 1'b0;
    hold = 1'b1;
    a = 32'd100; b = 32'd7; sgn = 1'b1; op = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (ready) got = 1;
      else begin @(posedge clk); #1; end
    end
    checks++; if (!got || hi !== 32'd2) begin errors++; $display("FAIL rst_pre_done: ready=%b hi=%h want 1/2", ready, hi); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (ready !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++; $display("FAIL rst_done: ready=%b hi=%h lo=%h want 0/0/0", ready, hi, lo);
    end
    $display("reset in DONE ready=%b hi=%h lo=%h", ready, hi, lo);
    @(posedge clk); #1;
    rst = 1'b0;
    hold = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rst_after: ready=%b stall=%b want 0/0", ready, stall); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div_signed;
    test_div_unsigned;
    test_div_zero;
    test_flush;
    test_hold;
    test_back_to_back;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
